// File: rtl/pipe_exc_ctrl.sv
// Exception controller for the 5-stage pipeline.
// It takes the oldest qualified request from IF/ID/EX and redirects the PC to
// the handler vector in the same cycle. It records EPC/Cause and then ignores
// all requests for a blanking window while the wrong path drains.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | armed; a qualified request is taken combinationally this cycle
// BLANK | exception just taken; requests ignored, bcnt counts down to 0
module pipe_exc_ctrl #(
  parameter int PC_WIDTH     = 32,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                Reset_L,
  input  logic [PC_WIDTH-1:0] exceptAddr,
  input  logic                stall,
  input  logic                if_adel,
  input  logic [PC_WIDTH-1:0] if_pc,
  input  logic                id_ri,
  input  logic                id_sys,
  input  logic [PC_WIDTH-1:0] id_pc,
  input  logic                ex_ov,
  input  logic [PC_WIDTH-1:0] ex_pc,
  output logic                flush_if,
  output logic                flush_id,
  output logic                flush_ex,
  output logic                pc_sel,
  output logic [PC_WIDTH-1:0] pc_redirect,
  output logic [PC_WIDTH-1:0] EPC,
  output logic [31:0]         Cause,
  output logic                exc_busy,
  output logic [7:0]          exc_count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BLANK = 1'b1
  } state_t;

  localparam logic [3:0] BCNT_LOAD = 4'(BLANK_CYCLES - 1);

  localparam logic [4:0] CODE_OV   = 5'd12;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_ADEL = 5'd4;

  state_t              state;
  logic [3:0]          bcnt;
  logic [4:0]          exc_code;

  logic                req_ov;
  logic                req_ri;
  logic                req_sys;
  logic                req_adel;
  logic                take;
  logic                src_ex;
  logic                src_id;
  logic [PC_WIDTH-1:0] sel_pc;
  logic [4:0]          sel_code;

  // Qualify requests: ID/IF sources wait out a stall, EX overflow never does.
  // Reset_L gates everything so no flush escapes while reset is held.
  always_comb begin
    req_ov   = ex_ov;
    req_ri   = id_ri   & ~stall;
    req_sys  = id_sys  & ~stall;
    req_adel = if_adel & ~stall;
    take     = Reset_L & (state == IDLE) & (req_ov | req_ri | req_sys | req_adel);
  end

  // Oldest-first selection of the winning source, its PC and its code.
  always_comb begin
    src_ex   = 1'b0;
    src_id   = 1'b0;
    sel_pc   = if_pc;
    sel_code = CODE_ADEL;
    if (req_ov) begin
      src_ex   = 1'b1;
      sel_pc   = ex_pc;
      sel_code = CODE_OV;
    end else if (req_ri) begin
      src_id   = 1'b1;
      sel_pc   = id_pc;
      sel_code = CODE_RI;
    end else if (req_sys) begin
      src_id   = 1'b1;
      sel_pc   = id_pc;
      sel_code = CODE_SYS;
    end
  end

  // Flush every stage younger than or equal to the faulting one; redirect now.
  always_comb begin
    flush_if = take;
    flush_id = take & (src_ex | src_id);
    flush_ex = take & src_ex;
    pc_sel   = take;
  end

  assign pc_redirect = exceptAddr;
  assign exc_busy    = (state == BLANK);
  assign Cause       = {25'b0, exc_code, 2'b00};

  // State, blank counter and the architectural exception record.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= IDLE;
      bcnt      <= 4'd0;
      EPC       <= '0;
      exc_code  <= 5'd0;
      exc_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            EPC      <= sel_pc;
            exc_code <= sel_code;
            if (exc_count != 8'hFF) begin
              exc_count <= exc_count + 8'd1;
            end
            bcnt  <= BCNT_LOAD;
            state <= BLANK;
          end
        end
        BLANK: begin
          if (bcnt == 4'd0) begin
            state <= IDLE;
          end else begin
            bcnt <= bcnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          bcnt  <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_exc_ctrl.sv
// Scoreboard bench for pipe_exc_ctrl: a reference model predicts each cycle's
// outputs, a monitor compares them at the falling edge.
module tb_pipe_exc_ctrl;

  localparam int PW    = 32;
  localparam int BLANK = 2;

  logic          CLK = 1'b0;
  logic          Reset_L;
  logic [PW-1:0] exceptAddr;
  logic          stall;
  logic          if_adel;
  logic [PW-1:0] if_pc;
  logic          id_ri;
  logic          id_sys;
  logic [PW-1:0] id_pc;
  logic          ex_ov;
  logic [PW-1:0] ex_pc;
  logic          flush_if, flush_id, flush_ex, pc_sel, exc_busy;
  logic [PW-1:0] pc_redirect, EPC;
  logic [31:0]   Cause;
  logic [7:0]    exc_count;

  pipe_exc_ctrl #(.PC_WIDTH(PW), .BLANK_CYCLES(BLANK)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .exceptAddr(exceptAddr), .stall(stall),
    .if_adel(if_adel), .if_pc(if_pc), .id_ri(id_ri), .id_sys(id_sys),
    .id_pc(id_pc), .ex_ov(ex_ov), .ex_pc(ex_pc), .flush_if(flush_if),
    .flush_id(flush_id), .flush_ex(flush_ex), .pc_sel(pc_sel),
    .pc_redirect(pc_redirect), .EPC(EPC), .Cause(Cause),
    .exc_busy(exc_busy), .exc_count(exc_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        busy, fi, fd, fe, psel;
    logic [31:0] redir, epc, cause;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_on = 1'b0;

  // reference model state
  logic [31:0] m_epc;
  int          m_code;
  int          m_cnt;
  int          m_blank_left;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endfunction

  task automatic model_reset();
    m_epc = 0; m_code = 0; m_cnt = 0; m_blank_left = 0;
  endtask

  // Drive one cycle of inputs and push the predicted outputs for that cycle.
  task automatic step(input logic ov, ri, sys, adel, st,
                      input logic [31:0] pex, pid, pif, ea);
    exp_t e;
    bit taken;
    int code;
    logic [31:0] pc;
    @(posedge CLK);
    #1;
    ex_ov = ov; id_ri = ri; id_sys = sys; if_adel = adel; stall = st;
    ex_pc = pex; id_pc = pid; if_pc = pif; exceptAddr = ea;
    e.busy = (m_blank_left > 0);
    e.fi = 0; e.fd = 0; e.fe = 0;
    taken = 0; code = 0; pc = 0;
    if (!e.busy) begin
      if (ov)              begin taken = 1; code = 12; pc = pex; e.fi = 1; e.fd = 1; e.fe = 1; end
      else if (!st && ri)  begin taken = 1; code = 10; pc = pid; e.fi = 1; e.fd = 1; end
      else if (!st && sys) begin taken = 1; code = 8;  pc = pid; e.fi = 1; e.fd = 1; end
      else if (!st && adel) begin taken = 1; code = 4; pc = pif; e.fi = 1; end
    end
    e.psel  = taken;
    e.redir = ea;
    e.epc   = m_epc;
    e.cause = 32'(m_code * 4);
    e.cnt   = 8'(m_cnt);
    exp_q.push_back(e);
    if (taken) begin
      m_epc = pc;
      m_code = code;
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      m_blank_left = BLANK;
    end else if (e.busy) begin
      m_blank_left--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 32'h500);
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  always @(negedge CLK) begin
    if (chk_on) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("exc_busy", 32'(exc_busy), 32'(e.busy));
        check("flush_if", 32'(flush_if), 32'(e.fi));
        check("flush_id", 32'(flush_id), 32'(e.fd));
        check("flush_ex", 32'(flush_ex), 32'(e.fe));
        check("pc_sel", 32'(pc_sel), 32'(e.psel));
        check("pc_redirect", pc_redirect, e.redir);
        check("EPC", EPC, e.epc);
        check("Cause", Cause, e.cause);
        check("exc_count", 32'(exc_count), 32'(e.cnt));
      end
    end
  end

  task automatic check_reset_state(string tag);
    check({tag, "_busy"}, 32'(exc_busy), 0);
    check({tag, "_flush_if"}, 32'(flush_if), 0);
    check({tag, "_flush_id"}, 32'(flush_id), 0);
    check({tag, "_flush_ex"}, 32'(flush_ex), 0);
    check({tag, "_pc_sel"}, 32'(pc_sel), 0);
    check({tag, "_EPC"}, EPC, 0);
    check({tag, "_Cause"}, Cause, 0);
    check({tag, "_count"}, 32'(exc_count), 0);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    #2;
    Reset_L = 1'b1;
    ex_ov = 0; id_ri = 0; id_sys = 0; if_adel = 0; stall = 0;
    model_reset();
    exp_q.delete();
    chk_on = 1'b1;
  endtask

  initial begin
    Reset_L = 1'b0;
    exceptAddr = 32'h500; stall = 0; if_adel = 0; if_pc = 0;
    id_ri = 0; id_sys = 0; id_pc = 0; ex_ov = 0; ex_pc = 0;
    model_reset();

    // reset held with all requests toggling
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      ex_ov = i[0]; id_ri = ~i[0]; id_sys = 1; if_adel = 1; stall = i[1];
      ex_pc = $urandom; id_pc = $urandom; if_pc = $urandom;
      #2;
      check_reset_state("reset");
    end
    release_reset();

    // EX overflow
    step(1, 0, 0, 0, 0, 32'h534, 32'h0, 32'h0, 32'h500);
    idle(3);
    // priority: ov beats sys and adel
    step(1, 0, 1, 1, 0, 32'h40, 32'h44, 32'h49, 32'h500);
    idle(3);
    // ri beats sys, flush_ex stays low
    step(0, 1, 1, 0, 0, 32'h0, 32'h44, 32'h0, 32'h500);
    idle(3);
    // stall gating
    step(0, 0, 1, 0, 1, 32'h0, 32'h60, 32'h0, 32'h500);
    step(0, 0, 1, 0, 0, 32'h0, 32'h60, 32'h0, 32'h500);
    idle(3);
    step(1, 0, 0, 0, 1, 32'h70, 32'h0, 32'h0, 32'h500);
    idle(3);
    // blanking boundary: continuous AdEL, taken every BLANK+1 cycles
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h101, 32'h500);
    // handler vector change during BLANK
    step(1, 0, 0, 0, 0, 32'h800, 32'h0, 32'h0, 32'h600);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h700);
    idle(3);

    // reset asserted mid-BLANK
    step(1, 0, 0, 0, 0, 32'h900, 32'h0, 32'h0, 32'h500);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h500);
    @(negedge CLK);
    #2;
    chk_on = 1'b0;
    exp_q.delete();
    ex_ov = 1; id_sys = 1;
    Reset_L = 1'b0;
    #1;
    check_reset_state("midblank");
    release_reset();
    // first cycle after release accepts a request
    step(0, 0, 1, 0, 0, 32'h0, 32'hA0, 32'h0, 32'h500);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0, $urandom, $urandom, $urandom,
           ($urandom_range(0, 9) == 0) ? $urandom : 32'h500);
    end

    // saturation: 300 more exceptions
    for (int i = 0; i < 300 * (BLANK + 1); i++)
      step(1, 0, 0, 0, 0, 32'(i), 32'h0, 32'h0, 32'h500);
    idle(2);
    @(negedge CLK);
    #2;
    check("sat_count", 32'(exc_count), 255);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
